// File: rtl/pbit_synapse_mac.sv
// Synapse/bias generator: sequential MAC of +/-1 neighbour states against signed weights plus bias,
// scaled and clamped to a 6-bit signed z. Define PBIT_SYN_SATFLAG_EN to add the `sat` clamp flag.
module pbit_synapse_mac #(
  parameter int N     = 8,
  parameter int WW    = 8,
  parameter int SHIFT = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [N-1:0]          m_in,
  input  logic signed [WW-1:0]  h,
  output logic                  w_rd,
  output logic [$clog2(N)-1:0]  w_addr,
  input  logic signed [WW-1:0]  w_data,
  output logic                  busy,
  output logic signed [5:0]     z,
  output logic                  z_valid
`ifdef PBIT_SYN_SATFLAG_EN
  ,
  output logic                  sat
`endif
);

  localparam int AddrW = $clog2(N);
  localparam int AW    = WW + $clog2(N + 1) + 1;
  localparam logic signed [AW-1:0] ZMax = AW'(31);
  localparam logic signed [AW-1:0] ZMin = AW'(-32);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_DRAIN, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic                 accept;
  logic signed [AW-1:0] acc, w_ext, term, s;
  logic [N-1:0]         m_q;
  logic                 rd_q;
  logic [AddrW-1:0]     k_q;
  logic signed [5:0]    z_next;
`ifdef PBIT_SYN_SATFLAG_EN
  logic                 clamped;
`endif

  always_comb begin
    state_d = state_q;
    w_rd    = 1'b0;
    busy    = 1'b1;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        w_rd = 1'b1;
        if (w_addr == AddrW'(N - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Weight arrives one cycle after its read, so the sign comes from the address issued last cycle.
  always_comb begin
    w_ext = AW'(w_data);
    term  = m_q[k_q] ? w_ext : -w_ext;
    s     = acc >>> SHIFT;
    if (s > ZMax)      z_next = 6'b01_1111;
    else if (s < ZMin) z_next = 6'b10_0000;
    else               z_next = s[5:0];
  end

`ifdef PBIT_SYN_SATFLAG_EN
  always_comb clamped = (s > ZMax) || (s < ZMin);
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc     <= '0;
      m_q     <= '0;
      rd_q    <= 1'b0;
      k_q     <= '0;
      w_addr  <= '0;
      z       <= '0;
      z_valid <= 1'b0;
`ifdef PBIT_SYN_SATFLAG_EN
      sat     <= 1'b0;
`endif
    end else begin
      rd_q    <= w_rd;
      k_q     <= w_addr;
      z_valid <= 1'b0;
      if (accept) begin
        m_q    <= m_in;
        acc    <= AW'(h);
        w_addr <= '0;
      end else if (rd_q) begin
        acc <= acc + term;
      end
      if (w_rd) w_addr <= (w_addr == AddrW'(N - 1)) ? '0 : w_addr + AddrW'(1);
      if (state_q == ST_DONE) begin
        z       <= z_next;
        z_valid <= 1'b1;
`ifdef PBIT_SYN_SATFLAG_EN
        sat     <= clamped;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pbit_synapse_mac.sv
// Bench for pbit_synapse_mac (N=4, WW=8, SHIFT=2): timeline model checked every cycle plus
// literal expectations for the directed scenarios.
module tb_pbit_synapse_mac;
  localparam int N = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        m_in = '0;
  logic signed [7:0] h = '0;
  logic              w_rd;
  logic [1:0]        w_addr;
  logic signed [7:0] w_data;
  logic              busy;
  logic signed [5:0] z;
  logic              z_valid;
`ifdef PBIT_SYN_SATFLAG_EN
  logic              sat;
`endif

  int total = 0;
  int bad   = 0;

  pbit_synapse_mac #(.N(4), .WW(8), .SHIFT(2)) dut (
    .CLK(CLK), .RST(RST), .start(start), .m_in(m_in), .h(h),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .busy(busy),
    .z(z), .z_valid(z_valid)
`ifdef PBIT_SYN_SATFLAG_EN
    , .sat(sat)
`endif
  );

  always #5 CLK = ~CLK;

  // Weight memory with one-cycle read latency; junk on the bus when no read was issued.
  logic signed [7:0] wmem [4];
  logic              rd_seen = 1'b0;
  logic [1:0]        addr_seen = '0;
  logic [7:0]        junk = 8'h5A;
  always @(posedge CLK) begin
    rd_seen   <= w_rd;
    addr_seen <= w_addr;
    junk      <= 8'($urandom);
  end
  always_comb w_data = rd_seen ? wmem[addr_seen] : junk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void calc(input logic [3:0] m, input int hh, output int zz, output int st);
    int acc, s;
    acc = hh;
    for (int i = 0; i < 4; i++) acc += m[i] ? int'(wmem[i]) : -int'(wmem[i]);
    s  = (acc >= 0) ? acc / 4 : -((-acc + 3) / 4);
    st = 0;
    zz = s;
    if (s > 31) begin zz = 31; st = 1; end
    else if (s < -32) begin zz = -32; st = 1; end
  endfunction

  // Model: d counts edges since acceptance; outputs follow directly from that position.
  int active = 0, d = 0, pend_z = 0, pend_sat = 0;
  int exp_busy = 0, exp_rd = 0, exp_addr = 0, exp_zv = 0, exp_z = 0, exp_sat = 0;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      active = 0; d = 0; exp_busy = 0; exp_rd = 0; exp_addr = 0;
      exp_zv = 0; exp_z = 0; exp_sat = 0;
    end else begin
      exp_zv = 0;
      if (active != 0) d = d + 1;
      if (active != 0 && d == N + 2) begin
        exp_z = pend_z; exp_sat = pend_sat; exp_zv = 1; active = 0;
      end else if (active == 0 && start) begin
        active = 1; d = 0;
        calc(m_in, int'(h), pend_z, pend_sat);
      end
      exp_busy = active;
      exp_rd   = (active != 0 && d <= N - 1) ? 1 : 0;
      exp_addr = exp_rd != 0 ? d : 0;
    end
  end

  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      check("busy", int'(busy), exp_busy);
      check("w_rd", int'(w_rd), exp_rd);
      if (exp_rd != 0) check("w_addr", int'(w_addr), exp_addr);
      check("z_valid", int'(z_valid), exp_zv);
      check("z", int'(z), exp_z);
`ifdef PBIT_SYN_SATFLAG_EN
      check("sat", int'(sat), exp_sat);
`endif
    end
  end

  task automatic set_w(input int a, input int b, input int c, input int e);
    wmem[0] = 8'(a); wmem[1] = 8'(b); wmem[2] = 8'(c); wmem[3] = 8'(e);
  endtask

  // Call with inputs free to change before the next rising edge; returns 2ns after acceptance.
  task automatic launch(input logic [3:0] m, input int hh);
    start = 1'b1; m_in = m; h = 8'(hh);
    @(posedge CLK); #2;
    start = 1'b0;
  endtask

  task automatic wait_zv(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (z_valid) begin lat = i; break; end
    end
    if (lat == 0) check("z_valid_timeout", 0, 1);
  endtask

  task automatic do_eval(input logic [3:0] m, input int hh, input int exp_z_lit, input int exp_sat_lit,
                         input string name);
    int lat;
    @(posedge CLK); #2;
    launch(m, hh);
    wait_zv(lat);
    check({name, "_latency"}, lat, 7);
    check({name, "_z"}, int'(z), exp_z_lit);
`ifdef PBIT_SYN_SATFLAG_EN
    check({name, "_sat"}, int'(sat), exp_sat_lit);
`else
    if (exp_sat_lit < 0) check({name, "_sat"}, exp_sat_lit, 0);
`endif
  endtask

  int lat, cnt, zz, st;
  int seq [8];

  initial begin
    set_w(10, 20, 30, 40);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_z", int'(z), 0);
    check("rst_z_valid", int'(z_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_w_rd", int'(w_rd), 0);
    check("rst_w_addr", int'(w_addr), 0);
    #1 RST = 1'b1;

    // pin the model on hand-computed values
    calc(4'b0101, 0, zz, st);
    check("model_0101", zz, -5);
    set_w(127, 127, 127, 127);
    calc(4'b1111, 127, zz, st);
    check("model_pos_clamp", zz * 2 + st, 63);
    set_w(10, 20, 30, 40);

    do_eval(4'b1111, 0, 25, 0, "all_pos");
    do_eval(4'b0000, 0, -25, 0, "all_neg");
    do_eval(4'b0101, 0, -5, 0, "mixed");
    set_w(127, 127, 127, 127);
    do_eval(4'b1111, 127, 31, 1, "clamp_hi");
    set_w(-128, -128, -128, -128);
    do_eval(4'b1111, -128, -32, 1, "clamp_lo");
    set_w(10, 20, 30, 40);
    do_eval(4'b1111, 0, 25, 0, "before_abort");

    // abort mid-evaluation
    @(posedge CLK); #2;
    launch(4'b0000, 0);
    repeat (2) @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_w_rd", int'(w_rd), 0);
    check("abort_z", int'(z), 0);
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (z_valid) cnt++;
    end
    check("abort_no_zv", cnt, 0);
    do_eval(4'b0101, 0, -5, 0, "after_abort");

    // second start while busy is ignored
    @(posedge CLK); #2;
    launch(4'b1111, 0);
    @(posedge CLK); #2;
    launch(4'b0000, 0);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      if (z_valid) cnt++;
    end
    check("ignored_start_zv_count", cnt, 1);
    check("ignored_start_z", int'(z), 25);

    // back-to-back: start in the z_valid cycle
    do_eval(4'b0000, 0, -25, 0, "b2b_first");
    launch(4'b0101, 0);
    wait_zv(lat);
    check("b2b_latency", lat, 7);
    check("b2b_z", int'(z), -5);

    // address sequence
    @(posedge CLK); #2;
    launch(4'b1111, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (w_rd) begin
        if (cnt < 8) seq[cnt] = int'(w_addr);
        cnt++;
      end
    end
    check("addr_rd_cycles", cnt, 4);
    for (int i = 0; i < 4; i++) check("addr_seq", seq[i], i);
    repeat (3) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
